// File: rtl/conv_window_ctrl_pkg.sv
// conv_pkg: shared FSM encoding and output-map sizing for the window controller.
package conv_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
   function automatic int out_dim(input int img, input int nk, input int stride);
      return (img - nk) / stride + 1;
   endfunction
endpackage

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: column-in / window-out handshake bundle of the window controller.
interface conv_window_ctrl_if #(parameter int CW = 16);
   logic start, col_valid, col_ready, shift_en, arr_clr;
   logic win_valid, win_ready, busy, frame_done;
   logic [CW-1:0] win_x, win_y;
   modport master (
      input start, col_valid, win_ready,
      output col_ready, shift_en, arr_clr, win_valid, win_x, win_y, busy, frame_done
   );
   modport slave (
      output start, col_valid, win_ready,
      input col_ready, shift_en, arr_clr, win_valid, win_x, win_y, busy, frame_done
   );
endinterface

// File: rtl/conv_window_ctrl_pos_counter.sv
// conv_pos_counter: raster position, stride phase and output indices; flags qualifying columns.
module conv_pos_counter #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int NKX = 3,
   parameter int NKY = 3,
   parameter int STRIDE = 1,
   parameter int CW = 16
) (
   input logic clk,
   input logic rst,
   input logic clr,
   input logic acc,
   output logic qual,
   output logic last,
   output logic [CW-1:0] ox,
   output logic [CW-1:0] oy
);
   localparam logic [CW-1:0] W1 = CW'(IMG_W - 1);
   localparam logic [CW-1:0] H1 = CW'(IMG_H - 1);
   localparam logic [CW-1:0] KX1 = CW'(NKX - 1);
   localparam logic [CW-1:0] KY1 = CW'(NKY - 1);
   localparam logic [CW-1:0] S1 = CW'(STRIDE - 1);
   logic [CW-1:0] col, row, sx, sy, px, py;
   logic wrap;
   // phase of the column being accepted; pinned to 0 at the first full-window position
   always_comb begin
      px = (col == KX1) ? '0 : sx;
      py = (row == KY1) ? '0 : sy;
      wrap = col == W1;
      qual = col >= KX1 && row >= KY1 && px == '0 && py == '0;
      last = wrap && row == H1;
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
         sx <= '0;
         sy <= '0;
         ox <= '0;
         oy <= '0;
      end else if (acc) begin
         col <= wrap ? '0 : col + 1'b1;
         row <= wrap ? (last ? '0 : row + 1'b1) : row;
         sx <= (px == S1) ? '0 : px + 1'b1;
         sy <= wrap ? ((py == S1) ? '0 : py + 1'b1) : sy;
         ox <= wrap ? '0 : (qual ? ox + 1'b1 : ox);
         oy <= (wrap && row >= KY1 && py == '0) ? (last ? '0 : oy + 1'b1) : oy;
      end
   end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-scan sequencer feeding columns into the window array and
// presenting completed windows to the MAC array with valid/ready back-pressure.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int NKX = 3,
   parameter int NKY = 3,
   parameter int STRIDE = 1,
   parameter int CW = 16
) (
   input logic clk,
   input logic rst,
   conv_window_ctrl_if.master bus
);
   state_t state, state_n;
   logic qual, last;
   logic [CW-1:0] ox, oy;
   conv_pos_counter #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .NKX(NKX), .NKY(NKY), .STRIDE(STRIDE), .CW(CW)
   ) u_pos (
      .clk(clk), .rst(rst), .clr(bus.arr_clr), .acc(bus.shift_en),
      .qual(qual), .last(last), .ox(ox), .oy(oy)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = (state == IDLE && bus.start) ? RUN :
                (state == RUN && bus.shift_en && last) ? FLUSH :
                (state == FLUSH && (!bus.win_valid || bus.win_ready)) ? IDLE : state;
   end
   // col_ready depends only on window occupancy, never on col_valid
   always_comb begin
      bus.col_ready = state == RUN && (!bus.win_valid || bus.win_ready);
      bus.shift_en = bus.col_ready && bus.col_valid;
      bus.arr_clr = state == IDLE && bus.start;
      bus.busy = state != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.win_valid <= 1'b0;
         bus.win_x <= '0;
         bus.win_y <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.frame_done <= state == FLUSH && (!bus.win_valid || bus.win_ready);
         if (bus.arr_clr) begin
            bus.win_valid <= 1'b0;
         end else if (bus.shift_en && qual) begin
            bus.win_valid <= 1'b1;
            bus.win_x <= ox;
            bus.win_y <= oy;
         end else if (bus.win_valid && bus.win_ready) begin
            bus.win_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Raster-scan sequencer for the sliding-window register array. It accepts one pixel column per handshake from the line buffers and drives the array's shift enable. It tracks column and row position and decides which array states are complete windows at the configured stride. It presents those windows to the MAC array with a valid/ready handshake, applying back-pressure upstream while a window is held.

Parameters:
IMG_W, 32, image width in pixels (columns per row); must be >= NKX
IMG_H, 32, image height in rows; must be >= NKY
NKX, 3, window width; must match the register array
NKY, 3, window height; must match the register array
STRIDE, 1, window step in both x and y; must be >= 1
CW, 16, width of the column/row/output-coordinate counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE
col_valid  in  1  upstream column available
col_ready  out  1  controller accepts column this cycle
shift_en  out  1  enable to the register array; high for exactly one cycle per accepted column
arr_clr  out  1  one-cycle clear to the register array on frame start
win_valid  out  1  register array currently holds a window to be consumed
win_ready  in  1  MAC array consumes the window
win_x  out  CW  output-map column index of the presented window
win_y  out  CW  output-map row index of the presented window
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last window of the frame is consumed

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; col_ready, shift_en, arr_clr, win_valid, busy and frame_done all 0; win_x, win_y and all counters 0.
- States: IDLE, RUN, FLUSH.
- IDLE -> RUN on start.
  - arr_clr=1 for that single cycle.
  - col, row, ox, oy, sx and sy all cleared.
- RUN: col_ready = !win_valid || win_ready.
  - A column is accepted when col_valid && col_ready.
  - shift_en = acceptance, combinationally, in the same cycle.
  - No combinational path from col_valid to col_ready.
- Position counters on acceptance:
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - row = bottom row of the column just shifted in.
- Phase counters:
  - sx counts modulo STRIDE. It is reset to 0 when the accepted column has col==NKX-1 and increments on each later accepted column.
  - sy counts modulo STRIDE. It is reset at row==NKY-1 and advances on each row wrap.
- Window qualification: the accepted column qualifies when col>=NKX-1, row>=NKY-1, sx phase==0 and sy phase==0.
  - win_valid rises the cycle after the qualifying acceptance, aligned with the array's registered output.
  - win_x and win_y are updated in that same cycle.
- Window consumption: win_valid falls on win_valid && win_ready unless a new qualifying column is accepted in the same cycle, in which case it stays high.
- Window indices:
  - ox increments per emitted window and resets at each row wrap.
  - oy increments per emitted row of windows.
- Row-start columns: the first NKX-1 columns of each row never qualify, because they hold stale data from the previous row.
- Holding: while win_valid && !win_ready, col_ready=0, shift_en=0, and win_x/win_y are stable.
- Last column: accepting col==IMG_W-1 with row==IMG_H-1 moves RUN -> FLUSH.
- FLUSH: col_ready=0. When win_valid is 0, or on the win_valid && win_ready cycle, the next cycle has frame_done=1 and state=IDLE.
- Window counts per frame:
  - Windows per row = (IMG_W-NKX)/STRIDE+1.
  - Rows of windows = (IMG_H-NKY)/STRIDE+1.
  - Integer division; trailing partial positions are dropped.
- Boundary cases:
  - start while busy: ignored.
  - col_valid in IDLE or FLUSH: not accepted.
  - rst mid-frame: returns to IDLE with the reset values above on the next edge; the held window is discarded.
  - Simultaneous consume and qualifying acceptance: both occur and the window is replaced.
- Counter widths: CW wide; comparisons use parameters extended to CW. Counters never exceed IMG_W-1 or IMG_H-1.

Decomposition:
- Shared package conv_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2);
  - a function computing output-map dimensions from IMG_W/IMG_H/NKX/NKY/STRIDE.
- One natural sub-module: conv_pos_counter. It holds col/row with wrap, the sx/sy stride phase and the ox/oy output indices, and emits a qualify flag. Handshake and FSM stay in the top.

Test Plan:
- IMG_W=5, IMG_H=4, NKX=NKY=3, STRIDE=1, col_valid=1, win_ready=1:
  - 20 shift_en pulses and 6 windows;
  - (win_x,win_y) in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1);
  - first win_valid one cycle after the 3rd column of row 2;
  - frame_done one cycle after the last consume.
- IMG_W=IMG_H=7, STRIDE=2, NKX=NKY=3: 9 windows with win_x,win_y in {0,1,2}; qualifying columns are col 2,4,6 in rows 2,4,6 only.
- Back-pressure: hold win_ready=0 for 5 cycles at the first window:
  - col_ready=0 and shift_en=0 for those cycles, win_x/win_y stable;
  - accepting resumes the cycle win_ready=1;
  - total window count unchanged.
- Random col_valid gaps (50%) with win_ready=1: window sequence and count identical to the first scenario; shift_en never high without col_valid.
- rst asserted mid-row 2: next cycle busy=0 and win_valid=0. A following start gives arr_clr=1 and a complete, correct 6-window frame.
- start pulsed during RUN: no effect on counters. arr_clr stays 0.
